// File: rtl/regfile_write_arbiter_if.sv
// Purpose: bundles the two result sources and the register-file write port of the write arbiter.
// Latency: none, this is a wire bundle.
// Backpressure: b_ready is driven by the arbiter; the A side is never stalled by the bus.
//
// Ports:
//   A side   : a_valid, a_addr, a_data (pipeline writeback).
//   B side   : b_valid, b_ready, b_addr, b_data (multicycle results).
//   RF port  : rd_address, rd_value, reg_write.
//   Status   : pending_mask, stall_pipe, fifo_count.
//   modport master is the result producer and register-file consumer; modport slave is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                      a_valid;
    logic [4:0]                a_addr;
    logic [31:0]               a_data;
    logic                      b_valid;
    logic                      b_ready;
    logic [4:0]                b_addr;
    logic [31:0]               b_data;
    logic [4:0]                rd_address;
    logic [31:0]               rd_value;
    logic                      reg_write;
    logic [31:0]               pending_mask;
    logic                      stall_pipe;
    logic [$clog2(DEPTH):0]    fifo_count;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  b_ready, rd_address, rd_value, reg_write, pending_mask, stall_pipe, fifo_count
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output b_ready, rd_address, rd_value, reg_write, pending_mask, stall_pipe, fifo_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: merges pipeline writeback (A) and buffered multicycle results (B) onto one register-file write port.
// Latency: 1 cycle from selection to rd_*; a B entry needs at least 2 edges from push to write.
// Backpressure: A is never stalled; B stalls when the FIFO is full (b_ready = !full); stall_pipe asks the pipeline to yield.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset.
//   bus        : slave side of regfile_write_arbiter_if (A/B inputs, RF write port, status outputs).
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    regfile_write_arbiter_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic [4:0]      rd_address_q, rd_address_d;
    logic [31:0]     rd_value_q, rd_value_d;
    logic            reg_write_q, reg_write_d;

    logic            full, empty, push, pop;
    entry_t          head;
    logic [31:0]     pending;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        // A always wins; B only drains in cycles A is idle.
        push  = bus.b_valid && !full;
        pop   = !bus.a_valid && !empty;
        head  = mem_q[rd_ptr_q];

        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Push and pop never hit the same slot: a push needs !full and a pop needs !empty.
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: bus.b_addr, data: bus.b_data};
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Output stage: hold address/data when idle, only the enable drops.
        rd_address_d = rd_address_q;
        rd_value_d   = rd_value_q;
        reg_write_d  = 1'b0;
        if (bus.a_valid) begin
            rd_address_d = bus.a_addr;
            rd_value_d   = bus.a_data;
            reg_write_d  = (bus.a_addr != 5'd0);
        end else if (pop) begin
            rd_address_d = head.addr;
            rd_value_d   = head.data;
            reg_write_d  = (head.addr != 5'd0);
        end

        // Counts only cycles where queued B work loses to A; any pop or empty FIFO clears it.
        if (!empty && bus.a_valid) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        end else begin
            starve_d = '0;
        end
        stall_d = (starve_d == SW'(STARVE_LIMIT));
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pending[mem_q[i].addr] = 1'b1;
            end
        end
        // r0 is hardwired, so it is never a hazard.
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            vld_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            stall_q      <= 1'b0;
            rd_address_q <= '0;
            rd_value_q   <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            vld_q        <= vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
            rd_address_q <= rd_address_d;
            rd_value_q   <= rd_value_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign bus.b_ready      = !full;
    assign bus.rd_address   = rd_address_q;
    assign bus.rd_value     = rd_value_q;
    assign bus.reg_write    = reg_write_q;
    assign bus.pending_mask = pending;
    assign bus.stall_pipe   = stall_q;
    assign bus.fifo_count   = count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: self-checking bench for regfile_write_arbiter using a reference queue model and directed steps.
// Latency: checks outputs 1 ns after each rising edge against the model's expected write.
// Backpressure: model predicts b_ready from its own queue occupancy.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
    } wr_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        bq[$];
    wr_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [4:0]  m_addr   = '0;
    logic [31:0] m_data   = '0;
    int          m_starve = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (bq[i]) m[bq[i].addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        bq.delete();
        exp_q.delete();
        m_addr   = '0;
        m_data   = '0;
        m_starve = 0;
    endtask

    // One clock: predict the edge from current inputs, then compare after it.
    task automatic tick();
        wr_t  e;
        ent_t h;
        logic rdy;
        rdy = (bq.size() < DEPTH);
        chk("b_ready", 32'(bus.b_ready), 32'(rdy));
        e.we   = 1'b0;
        e.addr = m_addr;
        e.data = m_data;
        if (bus.a_valid) begin
            e.addr = bus.a_addr;
            e.data = bus.a_data;
            e.we   = (bus.a_addr != 5'd0);
            if (bq.size() > 0) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else               m_starve = 0;
        end else begin
            m_starve = 0;
            if (bq.size() > 0) begin
                h      = bq.pop_front();
                e.addr = h.addr;
                e.data = h.data;
                e.we   = (h.addr != 5'd0);
            end
        end
        if (bus.b_valid && rdy) bq.push_back('{addr: bus.b_addr, data: bus.b_data});
        m_addr = e.addr;
        m_data = e.data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("reg_write",    32'(bus.reg_write),  32'(e.we));
        chk("rd_address",   32'(bus.rd_address), 32'(e.addr));
        chk("rd_value",     bus.rd_value,        e.data);
        chk("fifo_count",   32'(bus.fifo_count), 32'(bq.size()));
        chk("pending_mask", bus.pending_mask,    model_mask());
        chk("stall_pipe",   32'(bus.stall_pipe), 32'(m_starve == LIMIT));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_reg_write"},  32'(bus.reg_write),  32'd0);
        chk({tag, "_rd_address"}, 32'(bus.rd_address), 32'd0);
        chk({tag, "_rd_value"},   bus.rd_value,        32'd0);
        chk({tag, "_b_ready"},    32'(bus.b_ready),    32'd1);
        chk({tag, "_pending"},    bus.pending_mask,    32'd0);
        chk({tag, "_stall"},      32'(bus.stall_pipe), 32'd0);
        chk({tag, "_count"},      32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // A only
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
        tick();
        chk("a_addr5",  32'(bus.rd_address), 32'd5);
        chk("a_data5",  bus.rd_value,        32'hDEADBEEF);
        chk("a_we5",    32'(bus.reg_write),  32'd1);
        bus.a_addr = 5'd0; bus.a_data = 32'h1234;
        tick();
        chk("a_r0_we",  32'(bus.reg_write),  32'd0);

        // B buffering, no bypass
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'd7;
        tick();
        chk("b_pend9",   32'(bus.pending_mask[9]), 32'd1);
        chk("b_nobypass", 32'(bus.reg_write),      32'd0);
        bus.b_valid = 1'b0;
        tick();
        chk("b_addr9",   32'(bus.rd_address),      32'd9);
        chk("b_data7",   bus.rd_value,             32'd7);
        chk("b_we9",     32'(bus.reg_write),       32'd1);
        chk("b_pend9clr", 32'(bus.pending_mask[9]), 32'd0);

        // Full FIFO while A holds the port
        bus.a_valid = 1'b1; bus.a_addr = 5'd3;
        for (int i = 0; i < 5; i++) begin
            bus.b_valid = 1'b1;
            bus.b_addr  = 5'(10 + i);
            bus.b_data  = 32'(100 + i);
            bus.a_data  = 32'(i);
            tick();
            if (i == 3) begin
                chk("full_ready", 32'(bus.b_ready),    32'd0);
                chk("full_count", 32'(bus.fifo_count), 32'd4);
            end
        end
        chk("full_count5", 32'(bus.fifo_count), 32'd4);
        bus.b_valid = 1'b0; bus.a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_addr", 32'(bus.rd_address), 32'(10 + i));
            chk("drain_data", bus.rd_value,        32'(100 + i));
            chk("drain_we",   32'(bus.reg_write),  32'd1);
        end
        chk("drain_empty", 32'(bus.fifo_count), 32'd0);

        // Starvation
        bus.b_valid = 1'b1; bus.b_addr = 5'd20; bus.b_data = 32'd20;
        tick();
        bus.b_valid = 1'b0; bus.a_valid = 1'b1; bus.a_addr = 5'd4;
        for (int i = 1; i <= 8; i++) begin
            bus.a_data = 32'(i);
            tick();
            if (i == 7) chk("starve7", 32'(bus.stall_pipe), 32'd0);
        end
        chk("starve8", 32'(bus.stall_pipe), 32'd1);
        bus.a_data = 32'hA5A5;
        tick();
        chk("starve_sat",   32'(bus.stall_pipe), 32'd1);
        chk("starve_awins", bus.rd_value,        32'hA5A5);
        chk("starve_kept",  32'(bus.fifo_count), 32'd1);
        bus.a_valid = 1'b0;
        tick();
        chk("starve_clr",  32'(bus.stall_pipe), 32'd0);
        chk("starve_pop",  32'(bus.rd_address), 32'd20);

        // Simultaneous push and pop at count 2, then r0 entry
        bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.b_valid = 1'b1;
        bus.b_addr = 5'd21; bus.b_data = 32'd21; tick();
        bus.b_addr = 5'd22; bus.b_data = 32'd22; tick();
        chk("pp_pre", 32'(bus.fifo_count), 32'd2);
        bus.a_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'd55;
        tick();
        chk("pp_count", 32'(bus.fifo_count), 32'd2);
        chk("pp_addr",  32'(bus.rd_address), 32'd21);
        bus.b_valid = 1'b0;
        tick();
        tick();
        chk("r0_we",    32'(bus.reg_write),  32'd0);
        chk("r0_popped", 32'(bus.fifo_count), 32'd0);

        // Reset mid-operation discards queued entries
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.b_addr = 5'd17; bus.b_data = 32'd17; tick();
        bus.b_addr = 5'd18; bus.b_data = 32'd18; tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_we", 32'(bus.reg_write), 32'd0);

        // Mixed traffic against the model
        for (int i = 0; i < 80; i++) begin
            bus.a_valid = ($urandom_range(0, 2) == 0);
            bus.a_addr  = 5'($urandom_range(0, 7));
            bus.a_data  = $urandom;
            bus.b_valid = ($urandom_range(0, 1) == 1);
            bus.b_addr  = 5'($urandom_range(0, 7));
            bus.b_data  = $urandom;
            tick();
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        repeat (DEPTH + 1) tick();
        chk("final_empty", 32'(bus.fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
